// File: rtl/inst_queue.sv
// inst_queue: circular instruction queue between if_stage and dual-issue decode.
//
// Each cycle the queue accepts at most one fetched instruction and shows the
// two oldest entries to the issue logic, which retires 0, 1 or 2 of them.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   flush                           empties the queue; beats push and pop
//   push_i, push_inst_i/pc_i/exc_i  fetched instruction (one per cycle max)
//   issue_num_i, issue_stall_i      entries consumed by decode (3 reads as 0)
//   inst0_o/pc0_o/exc0_o, valid0_o  oldest entry
//   inst1_o/pc1_o/exc1_o, valid1_o  second-oldest entry
//   instBufferFull                  back-pressure to if_stage
//   count_o                         occupancy, 0..DEPTH
//   overflow_o                      sticky: a push arrived with no free slot
//
// Handshake: a push is a one-cycle valid with no ready. The producer is
// throttled by instBufferFull, which asserts two entries early so the fetch
// already in flight when it is sampled still finds a slot. On the issue side,
// valid0_o/valid1_o say which slots hold real entries. Decode retires
// issue_num_i of them at the clock edge; requests past the occupancy are
// clipped rather than flagged.
module inst_queue #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,
   input  logic          push_i,
   input  logic [31:0]   push_inst_i,
   input  logic [31:0]   push_pc_i,
   input  logic [4:0]    push_exc_i,
   input  logic [1:0]    issue_num_i,
   input  logic          issue_stall_i,
   output logic [31:0]   inst0_o,
   output logic [31:0]   pc0_o,
   output logic [4:0]    exc0_o,
   output logic [31:0]   inst1_o,
   output logic [31:0]   pc1_o,
   output logic [4:0]    exc1_o,
   output logic          valid0_o,
   output logic          valid1_o,
   output logic          instBufferFull,
   output logic [AW:0]   count_o,
   output logic          overflow_o
);

   localparam logic [4:0]  EXC_NONE  = 5'h00;
   localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW:0] FULL_MARK = (AW+1)'(DEPTH - 2);

   logic [31:0] inst_mem [DEPTH];
   logic [31:0] pc_mem   [DEPTH];
   logic [4:0]  exc_mem  [DEPTH];

   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, rd1;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;

   logic [1:0]    req;
   logic [1:0]    pop;
   logic [AW:0]   pop_w;
   logic          acc;

   always_comb begin
      req = (issue_num_i == 2'd3) ? 2'd0 : issue_num_i;
      pop = 2'd0;
      if (!issue_stall_i) begin
         // Clip to occupancy; count is below 2 whenever clipping applies.
         if ({{(AW-1){1'b0}}, req} > count_q) pop = count_q[1:0];
         else                                  pop = req;
      end
      pop_w = {{(AW-1){1'b0}}, pop};
      // A same-cycle pop frees a slot, so a push at full with pop>=1 fits.
      acc   = push_i && ((count_q - pop_w) < DEPTH_C);

      rd_d       = rd_q + {{(AW-2){1'b0}}, pop};
      wr_d       = wr_q + {{(AW-1){1'b0}}, acc};
      count_d    = count_q + {{AW{1'b0}}, acc} - pop_w;
      overflow_d = overflow_q | (push_i & ~acc & ~flush);
      if (flush) begin
         rd_d    = '0;
         wr_d    = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; valid gating on the read side hides stale data.
   always_ff @(posedge clk) begin
      if (acc && !flush) begin
         inst_mem[wr_q] <= push_inst_i;
         pc_mem[wr_q]   <= push_pc_i;
         exc_mem[wr_q]  <= push_exc_i;
      end
   end

   always_comb begin
      rd1      = rd_q + {{(AW-1){1'b0}}, 1'b1};
      valid0_o = (count_q >= (AW+1)'(1));
      valid1_o = (count_q >= (AW+1)'(2));
      inst0_o  = valid0_o ? inst_mem[rd_q] : 32'h0;
      pc0_o    = valid0_o ? pc_mem[rd_q]   : 32'h0;
      exc0_o   = valid0_o ? exc_mem[rd_q]  : EXC_NONE;
      inst1_o  = valid1_o ? inst_mem[rd1]  : 32'h0;
      pc1_o    = valid1_o ? pc_mem[rd1]    : 32'h0;
      exc1_o   = valid1_o ? exc_mem[rd1]   : EXC_NONE;
   end

   assign instBufferFull = (count_q >= FULL_MARK);
   assign count_o        = count_q;
   assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed and randomized bench for inst_queue, compared each
// cycle against a queue-based reference model of the occupancy rules.
module tb_inst_queue;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [4:0]  exc;
   } entry_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic          flush = 1'b0;
   logic          push_i = 1'b0;
   logic [31:0]   push_inst_i = '0;
   logic [31:0]   push_pc_i = '0;
   logic [4:0]    push_exc_i = '0;
   logic [1:0]    issue_num_i = '0;
   logic          issue_stall_i = 1'b0;
   logic [31:0]   inst0_o, pc0_o, inst1_o, pc1_o;
   logic [4:0]    exc0_o, exc1_o;
   logic          valid0_o, valid1_o, instBufferFull, overflow_o;
   logic [AW:0]   count_o;

   inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .push_i(push_i), .push_inst_i(push_inst_i), .push_pc_i(push_pc_i),
      .push_exc_i(push_exc_i), .issue_num_i(issue_num_i),
      .issue_stall_i(issue_stall_i),
      .inst0_o(inst0_o), .pc0_o(pc0_o), .exc0_o(exc0_o),
      .inst1_o(inst1_o), .pc1_o(pc1_o), .exc1_o(exc1_o),
      .valid0_o(valid0_o), .valid1_o(valid1_o),
      .instBufferFull(instBufferFull), .count_o(count_o),
      .overflow_o(overflow_o)
   );

   // ---------------- reference model / scoreboard ----------------
   entry_t      exp_q[$];
   logic        m_ovf = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] next_pc = 32'hBFC0_0000;
   int          total_acc = 0;
   int          total_pop = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int n;
      n = exp_q.size();
      chk("count", 64'(count_o), 64'(n));
      chk("valid0", 64'(valid0_o), 64'(n >= 1));
      chk("valid1", 64'(valid1_o), 64'(n >= 2));
      chk("pc0",   64'(pc0_o),   (n >= 1) ? 64'(exp_q[0].pc)   : 64'd0);
      chk("inst0", 64'(inst0_o), (n >= 1) ? 64'(exp_q[0].inst) : 64'd0);
      chk("exc0",  64'(exc0_o),  (n >= 1) ? 64'(exp_q[0].exc)  : 64'd0);
      chk("pc1",   64'(pc1_o),   (n >= 2) ? 64'(exp_q[1].pc)   : 64'd0);
      chk("inst1", 64'(inst1_o), (n >= 2) ? 64'(exp_q[1].inst) : 64'd0);
      chk("exc1",  64'(exc1_o),  (n >= 2) ? 64'(exp_q[1].exc)  : 64'd0);
      chk("full", 64'(instBufferFull), 64'(n >= DEPTH - 2));
      chk("overflow", 64'(overflow_o), 64'(m_ovf));
   endtask

   // ---------------- driver ----------------
   // Drives one cycle of inputs, advances the model across the edge, checks.
   task automatic cycle(input logic p, input logic [1:0] num, input logic st, input logic fl);
      entry_t e;
      int     n;
      logic   acc;
      e.inst = $urandom;
      e.pc   = next_pc;
      e.exc  = ($urandom_range(0, 3) == 0) ? 5'h04 : 5'h00;
      push_i = p; push_inst_i = e.inst; push_pc_i = e.pc; push_exc_i = e.exc;
      issue_num_i = num; issue_stall_i = st; flush = fl;
      if (p) next_pc += 32'd4;

      n = (num == 2'd3 || st) ? 0 : int'(num);
      if (n > exp_q.size()) n = exp_q.size();
      acc = p && (exp_q.size() - n < DEPTH);

      @(posedge clk);
      #1;
      if (fl) begin
         exp_q.delete();
      end else begin
         if (p && !acc) m_ovf = 1'b1;
         repeat (n) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(e);
         total_pop += n;
         if (acc) total_acc++;
      end
      push_i = 1'b0; flush = 1'b0; issue_num_i = 2'd0; issue_stall_i = 1'b0;
      check_outputs();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic seen;
      // Reset state
      #12;
      check_outputs();
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      check_outputs();

      // Reset/fill
      cycle(1, 2'd0, 0, 0);
      chk("fill_cnt1", 64'(count_o), 64'd1);
      chk("fill_pc0", 64'(pc0_o), 64'hBFC0_0000);
      chk("fill_v1_lo", 64'(valid1_o), 64'd0);
      cycle(1, 2'd0, 0, 0);
      chk("fill_pc1", 64'(pc1_o), 64'hBFC0_0004);
      chk("fill_v1_hi", 64'(valid1_o), 64'd1);
      cycle(1, 2'd0, 0, 0);
      chk("fill_cnt3", 64'(count_o), 64'd3);

      // Dual issue with clipping
      cycle(0, 2'd2, 0, 0);
      chk("dual_cnt1", 64'(count_o), 64'd1);
      chk("dual_pc0", 64'(pc0_o), 64'hBFC0_0008);
      cycle(0, 2'd2, 0, 0);
      chk("dual_cnt0", 64'(count_o), 64'd0);
      chk("dual_v0", 64'(valid0_o), 64'd0);

      // Push into empty with issue 1: entry held
      cycle(1, 2'd1, 0, 0);
      chk("empty_push_hold", 64'(count_o), 64'd1);
      cycle(0, 2'd3, 0, 0);
      chk("issue3_is_0", 64'(count_o), 64'd1);
      cycle(0, 2'd1, 0, 0);

      // Back-pressure
      seen = 1'b0;
      for (int i = 0; i < 32 && !seen; i++) begin
         cycle(1, 2'd0, 0, 0);
         if (instBufferFull) seen = 1'b1;
      end
      chk("bp_seen", 64'(seen), 64'd1);
      chk("bp_full_at", 64'(count_o), 64'd14);
      cycle(1, 2'd0, 0, 0);
      cycle(0, 2'd0, 0, 0);
      chk("bp_cnt15", 64'(count_o), 64'd15);
      chk("bp_no_ovf", 64'(overflow_o), 64'd0);

      // Overflow, then push at full with pop
      cycle(1, 2'd0, 0, 0);
      chk("ovf_cnt16", 64'(count_o), 64'd16);
      cycle(1, 2'd0, 0, 0);
      chk("ovf_set", 64'(overflow_o), 64'd1);
      chk("ovf_drop", 64'(count_o), 64'd16);
      cycle(1, 2'd1, 0, 0);
      chk("full_pushpop", 64'(count_o), 64'd16);
      cycle(0, 2'd0, 0, 0);
      chk("ovf_sticky", 64'(overflow_o), 64'd1);
      for (int i = 0; i < 20 && count_o != 0; i++) cycle(0, 2'd2, 0, 0);
      chk("drained", 64'(count_o), 64'd0);

      // Wrap: random traffic, producer obeys back-pressure
      total_acc = 0; total_pop = 0;
      for (int i = 0; i < 300; i++) begin
         cycle(!instBufferFull && ($urandom_range(0, 3) != 0),
               2'($urandom_range(1, 2)), ($urandom_range(0, 3) == 0), 0);
      end
      chk("wrap_volume", 64'(total_acc > 3 * DEPTH), 64'd1);
      chk("wrap_balance", 64'(count_o), 64'(total_acc - total_pop));

      // Flush with count=5, push and issue 2 in the same cycle
      for (int i = 0; i < 20 && count_o != 0; i++) cycle(0, 2'd2, 0, 0);
      repeat (5) cycle(1, 2'd0, 0, 0);
      chk("pre_flush_cnt", 64'(count_o), 64'd5);
      cycle(1, 2'd2, 0, 1);
      chk("flush_cnt", 64'(count_o), 64'd0);
      chk("flush_v0", 64'(valid0_o), 64'd0);
      cycle(0, 2'd0, 0, 0);
      chk("flush_absent", 64'(count_o), 64'd0);

      // Asynchronous reset mid-stream
      repeat (4) cycle(1, 2'd0, 0, 0);
      resetn = 1'b0;
      #1;
      exp_q.delete();
      m_ovf = 1'b0;
      chk("areset_cnt", 64'(count_o), 64'd0);
      chk("areset_ovf", 64'(overflow_o), 64'd0);
      check_outputs();
      @(posedge clk); #1;
      resetn = 1'b1;
      check_outputs();
      cycle(1, 2'd0, 0, 0);
      cycle(1, 2'd1, 0, 0);
      cycle(0, 2'd2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
